// File: rtl/aes_sub_bytes_seq.sv
// Sequential AES SubBytes engine: LANES bytes per cycle through the forward S-box.
// One 128-bit state in via valid/ready, result held on state_out until accepted.
module aes_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] state_out,
    output logic         busy
);

    localparam int NCYC = 16 / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    state_t        fsm;
    logic [0:127]  work;
    logic [0:127]  work_nxt;
    logic [CW-1:0] cnt;
    logic          last;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    assign last = (cnt == CW'(NCYC - 1));

    // Replace the current lane group in place; other bytes pass through.
    always_comb begin
        work_nxt = work;
        for (int l = 0; l < LANES; l++) begin
            int idx;
            idx = int'(cnt) * LANES + l;
            work_nxt[8*idx +: 8] = sbox(work[8*idx +: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            work      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state_out <= '0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        work     <= state_in;
                        cnt      <= '0;
                        fsm      <= SUB;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SUB: begin
                    work <= work_nxt;
                    if (last) begin
                        state_out <= work_nxt;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Directed bench for aes_sub_bytes_seq at LANES=1, 4 and 16.
// Reference S-box derived from GF(2^8) inversion plus the affine map.
module tb_aes_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [0:127] state_in;

    logic         ir4, ov4, b4;
    logic [0:127] so4;
    logic         ir1, ov1, b1;
    logic [0:127] so1;
    logic         ir16, ov16, b16;
    logic [0:127] so16;

    int pass_cnt = 0;
    int total    = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    always #5 clk = ~clk;

    aes_sub_bytes_seq #(.LANES(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
        .state_in(state_in), .out_valid(ov4), .out_ready(out_ready),
        .state_out(so4), .busy(b4)
    );

    aes_sub_bytes_seq #(.LANES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
        .state_in(state_in), .out_valid(ov1), .out_ready(out_ready),
        .state_out(so1), .busy(b1)
    );

    aes_sub_bytes_seq #(.LANES(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
        .state_in(state_in), .out_valid(ov16), .out_ready(out_ready),
        .state_out(so16), .busy(b16)
    );

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_model();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                    ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [0:127] d);
        in_valid = 1'b1;
        state_in = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!ov4 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        state_in  = 128'h0123456789abcdef0123456789abcdef;
        tick();
        tick();
        total++;
        if (ir4 !== 1'b1) $display("FAIL reset_in_ready got %b want 1", ir4);
        else pass_cnt++;
        total++;
        if (ov4 !== 1'b0) $display("FAIL reset_out_valid got %b want 0", ov4);
        else pass_cnt++;
        total++;
        if (so4 !== 128'h0) $display("FAIL reset_state_out got %h want 0", so4);
        else pass_cnt++;
        total++;
        if (b4 !== 1'b0) $display("FAIL reset_busy got %b want 0", b4);
        else pass_cnt++;
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        total++;
        if (b4 !== 1'b0) $display("FAIL reset_no_capture busy got %b want 0", b4);
        else pass_cnt++;
    endtask

    task automatic test_vector();
        int lat;
        logic [0:127] exp;
        exp = 128'h637ced16637ced16637ced16637ced16;
        send(128'h000153ff000153ff000153ff000153ff);
        total++;
        if (b4 !== 1'b1) $display("FAIL vec_busy got %b want 1", b4);
        else pass_cnt++;
        wait_out(lat);
        total++;
        if (lat != 4) $display("FAIL vec_latency got %0d want 4", lat);
        else pass_cnt++;
        total++;
        if (so4 !== exp) $display("FAIL vec_data got %h want %h", so4, exp);
        else pass_cnt++;
        total++;
        if (ir4 !== 1'b0) $display("FAIL vec_in_ready got %b want 0", ir4);
        else pass_cnt++;
        handshake();
        total++;
        if (ov4 !== 1'b0 || ir4 !== 1'b1 || b4 !== 1'b0)
            $display("FAIL vec_release ov/ir/busy got %b%b%b want 010", ov4, ir4, b4);
        else pass_cnt++;
        total++;
        if (so4 !== exp) $display("FAIL vec_hold_after got %h want %h", so4, exp);
        else pass_cnt++;
    endtask

    task automatic test_fips();
        int l1, l4, l16;
        logic [0:127] exp;
        exp = 128'hd42711aee0bf98f1b8b45de51e415230;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        l1  = -1;
        l4  = -1;
        l16 = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ov1 && l1 < 0) l1 = i;
            if (ov4 && l4 < 0) l4 = i;
            if (ov16 && l16 < 0) l16 = i;
        end
        total++;
        if (l1 != 16) $display("FAIL fips_lat_l1 got %0d want 16", l1);
        else pass_cnt++;
        total++;
        if (l4 != 4) $display("FAIL fips_lat_l4 got %0d want 4", l4);
        else pass_cnt++;
        total++;
        if (l16 != 1) $display("FAIL fips_lat_l16 got %0d want 1", l16);
        else pass_cnt++;
        total++;
        if (so1 !== exp) $display("FAIL fips_data_l1 got %h want %h", so1, exp);
        else pass_cnt++;
        total++;
        if (so4 !== exp) $display("FAIL fips_data_l4 got %h want %h", so4, exp);
        else pass_cnt++;
        total++;
        if (so16 !== exp) $display("FAIL fips_data_l16 got %h want %h", so16, exp);
        else pass_cnt++;
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        logic [0:127] exp_a;
        logic [0:127] exp_b;
        exp_a = 128'h637c777bf26b6fc53001672bfed7ab76;
        exp_b = {16{8'hed}};
        send(128'h000102030405060708090a0b0c0d0e0f);
        wait_out(lat);
        in_valid = 1'b1;
        state_in = {16{8'h53}};
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (so4 !== exp_a || ir4 !== 1'b0 || ov4 !== 1'b1) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL bp_hold bad_cycles got %0d want 0", bad);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (ir4 !== 1'b1 || ov4 !== 1'b0)
            $display("FAIL bp_release ir/ov got %b%b want 10", ir4, ov4);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total++;
        if (b4 !== 1'b1) $display("FAIL bp_accept busy got %b want 1", b4);
        else pass_cnt++;
        wait_out(lat);
        total++;
        if (lat != 4) $display("FAIL bp_latency got %0d want 4", lat);
        else pass_cnt++;
        total++;
        if (so4 !== exp_b) $display("FAIL bp_data got %h want %h", so4, exp_b);
        else pass_cnt++;
        handshake();
    endtask

    task automatic test_mid_reset();
        int lat;
        send(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (ir4 !== 1'b1 || ov4 !== 1'b0 || b4 !== 1'b0)
            $display("FAIL mr_ctrl ir/ov/busy got %b%b%b want 100", ir4, ov4, b4);
        else pass_cnt++;
        total++;
        if (so4 !== 128'h0) $display("FAIL mr_state_out got %h want 0", so4);
        else pass_cnt++;
        send(128'h0);
        wait_out(lat);
        total++;
        if (lat != 4) $display("FAIL mr_latency got %0d want 4", lat);
        else pass_cnt++;
        total++;
        if (so4 !== {16{8'h63}}) $display("FAIL mr_data got %h want all 63", so4);
        else pass_cnt++;
        handshake();
    endtask

    task automatic test_sweep();
        int lat;
        logic [0:127] din;
        logic [0:127] exp;
        logic [0:127] back;
        for (int s = 0; s < 16; s++) begin
            for (int k = 0; k < 16; k++) begin
                din[8*k +: 8] = 8'(16 * s + k);
                exp[8*k +: 8] = sb[16 * s + k];
            end
            send(din);
            wait_out(lat);
            total++;
            if (lat != 4 || so4 !== exp)
                $display("FAIL sweep_%0d got %h lat %0d want %h lat 4", s, so4, lat, exp);
            else pass_cnt++;
            for (int k = 0; k < 16; k++) back[8*k +: 8] = isb[so4[8*k +: 8]];
            total++;
            if (back !== din) $display("FAIL sweep_inv_%0d got %h want %h", s, back, din);
            else pass_cnt++;
            handshake();
        end
    endtask

    task automatic test_model_spots();
        total++;
        if (sb[8'h00] !== 8'h63 || sb[8'h01] !== 8'h7c || sb[8'h53] !== 8'hed || sb[8'hff] !== 8'h16)
            $display("FAIL model_spots got %h %h %h %h want 63 7c ed 16",
                     sb[8'h00], sb[8'h01], sb[8'h53], sb[8'hff]);
        else pass_cnt++;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        build_model();
        test_model_spots();
        test_reset();
        test_vector();
        test_fips();
        test_back_to_back();
        test_mid_reset();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
